binary_down_counter_ctl: RTL and testbench

- Loadable binary down-counter with terminal-count signalling. It is the counting-down counterpart of the team's 4-bit binary_up_counter.
- Software or a sequencer loads a start value through a valid/ready handshake. The block then decrements once per enabled cycle and flags terminal count.
- Two modes: one-shot (stop at zero) and auto-reload (wrap back to the loaded value).
- Used as a timeout/interval timer beside the up-counter in the Control/Counter group.

---
 rtl/binary_down_counter_ctl.sv | 95 +++++++++
 tb/tb_binary_down_counter_ctl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/binary_down_counter_ctl.sv
// Loadable down-counter with terminal-count pulse, one-shot / auto-reload modes
// and a sticky underflow flag; loads are accepted through a valid/ready handshake.
module binary_down_counter_ctl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_mode,
  input  logic             enable,
  input  logic             clear_underflow,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             tc_pulse,
  output logic             underflow,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             uf_q, uf_d;
  logic             load_fire;

  // A running counter only takes a new value while it is paused.
  assign load_ready = (state_q != ST_RUN) | ~enable;
  assign load_fire  = load_valid & load_ready;

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    uf_d     = uf_q & ~clear_underflow;

    if (load_fire) begin
      out_d    = load_value;
      reload_d = load_value;
      mode_d   = load_mode;
      state_d  = (load_value != '0) ? ST_RUN : ST_DONE;
    end else if ((state_q == ST_RUN) && enable) begin
      if (out_q > ONE) begin
        out_d = out_q - ONE;
      end else if (out_q == ONE) begin
        out_d = '0;
        tc_d  = 1'b1;
        if (mode_q) state_d = ST_DONE;
      end else if (!mode_q) begin
        // Wrap from zero back to the loaded value; a simultaneous clear loses.
        out_d = reload_q;
        uf_d  = 1'b1;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      uf_q     <= uf_d;
    end
  end

  assign out       = out_q;
  assign zero      = (out_q == '0);
  assign tc_pulse  = tc_q;
  assign underflow = uf_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_binary_down_counter_ctl.sv
// Directed scoreboard bench for binary_down_counter_ctl: the stimulus pushes the
// hand-computed post-edge outputs, a monitor pops and compares them each cycle.
module tb_binary_down_counter_ctl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             load_mode;
  logic             enable;
  logic             clear_underflow;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc_pulse;
  logic             underflow;
  logic             busy;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             tc;
    logic             uf;
    logic             busy;
    logic             rdy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  binary_down_counter_ctl #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_value      (load_value),
    .load_mode       (load_mode),
    .enable          (enable),
    .clear_underflow (clear_underflow),
    .out             (out),
    .zero            (zero),
    .tc_pulse        (tc_pulse),
    .underflow       (underflow),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge, when they have settled.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, ".out"},        32'(out),        32'(e.out));
        check({n, ".zero"},       32'(zero),       32'(e.zero));
        check({n, ".tc_pulse"},   32'(tc_pulse),   32'(e.tc));
        check({n, ".underflow"},  32'(underflow),  32'(e.uf));
        check({n, ".busy"},       32'(busy),       32'(e.busy));
        check({n, ".load_ready"}, 32'(load_ready), 32'(e.rdy));
      end
    end
  end

  // One clock cycle: inputs held across the edge; expectation is the state after it
  // (load_ready is evaluated with the same inputs still applied).
  task automatic step(input logic lv, input logic [WIDTH-1:0] val, input logic mode,
                      input logic en, input logic clr, input logic rst,
                      input logic [WIDTH-1:0] e_out, input logic e_zero, input logic e_tc,
                      input logic e_uf, input logic e_busy, input logic e_rdy,
                      input string name);
    exp_t e;
    load_valid      = lv;
    load_value      = val;
    load_mode       = mode;
    enable          = en;
    clear_underflow = clr;
    reset           = rst;
    @(posedge clk);
    e.out  = e_out;
    e.zero = e_zero;
    e.tc   = e_tc;
    e.uf   = e_uf;
    e.busy = e_busy;
    e.rdy  = e_rdy;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load_valid = 0; load_value = '0; load_mode = 0;
    enable = 0; clear_underflow = 0; reset = 1;

    //    lv val mode en clr rst | out z tc uf busy rdy
    // 1: reset, then enable in IDLE does nothing
    step(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1, "t1_rst0");
    step(0, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1, "t1_rst1");
    step(0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1, "t1_idle_en0");
    step(0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1, "t1_idle_en1");

    // 2: one-shot from 5
    step(1, 5, 1, 1, 0, 0,  5, 0, 0, 0, 1, 0, "t2_load5");
    step(0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 1, 0, "t2_c4");
    step(0, 0, 0, 1, 0, 0,  3, 0, 0, 0, 1, 0, "t2_c3");
    step(0, 0, 0, 1, 0, 0,  2, 0, 0, 0, 1, 0, "t2_c2");
    step(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, "t2_c1");
    step(0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 1, "t2_tc");
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 1, "t2_done_hold");

    // 3: auto-reload from 3, wrap sets sticky underflow
    step(1, 3, 0, 1, 0, 0,  3, 0, 0, 0, 1, 0, "t3_load3");
    step(0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 1, 0, "t3_c2");
    step(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, "t3_c1");
    step(0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 1, 0, "t3_tc0");
    step(0, 0, 0, 1, 0, 0,  3, 0, 0, 1, 1, 0, "t3_wrap0");
    step(0, 0, 0, 1, 0, 0,  2, 0, 0, 1, 1, 0, "t3_c2b");
    step(0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 0, "t3_c1b");
    step(0, 0, 0, 1, 0, 0,  0, 1, 1, 1, 1, 0, "t3_tc1");
    step(0, 0, 0, 1, 0, 0,  3, 0, 0, 1, 1, 0, "t3_wrap1");
    step(0, 0, 0, 0, 1, 0,  3, 0, 0, 0, 1, 1, "t3_clear_uf");

    // 4: load while paused; load with enable high in RUN is refused
    step(1, 9, 1, 1, 0, 0,  2, 0, 0, 0, 1, 0, "t4_load_refused");
    step(1, 9, 1, 0, 0, 0,  9, 0, 0, 0, 1, 1, "t4_load9");
    step(0, 0, 0, 1, 0, 0,  8, 0, 0, 0, 1, 0, "t4_c8");
    step(0, 0, 0, 1, 0, 0,  7, 0, 0, 0, 1, 0, "t4_c7");
    step(0, 0, 0, 1, 0, 0,  6, 0, 0, 0, 1, 0, "t4_c6");
    step(0, 0, 0, 0, 0, 0,  6, 0, 0, 0, 1, 1, "t4_pause");
    step(0, 0, 0, 0, 0, 0,  6, 0, 0, 0, 1, 1, "t4_pause_hold");
    step(1, 2, 1, 0, 0, 0,  2, 0, 0, 0, 1, 1, "t4_load2");
    step(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, "t4_c1");
    step(0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 1, "t4_tc");

    // 5: reset mid-count overrides a simultaneous load
    step(1, 7, 1, 1, 0, 0,  7, 0, 0, 0, 1, 0, "t5_load7");
    step(0, 0, 0, 1, 0, 0,  6, 0, 0, 0, 1, 0, "t5_c6");
    step(0, 0, 0, 1, 0, 0,  5, 0, 0, 0, 1, 0, "t5_c5");
    step(0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 1, 0, "t5_c4");
    step(1, 9, 0, 1, 0, 1,  0, 1, 0, 0, 0, 1, "t5_reset_mid");
    step(0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1, "t5_idle_after");

    // 6: reload of 1, clear coinciding with wrap loses, then load 0
    step(1, 1, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, "t6_load1");
    step(0, 0, 0, 1, 0, 0,  0, 1, 1, 0, 1, 0, "t6_tc0");
    step(0, 0, 0, 1, 1, 0,  1, 0, 0, 1, 1, 0, "t6_set_wins");
    step(0, 0, 0, 1, 0, 0,  0, 1, 1, 1, 1, 0, "t6_tc1");
    step(0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1, "t6_pause_at0");
    step(1, 0, 1, 0, 0, 0,  0, 1, 0, 1, 0, 1, "t6_load0");
    step(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 1, "t6_done_en");
    step(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 1, "t6_done_en2");
    step(0, 0, 0, 1, 0, 1,  0, 1, 0, 0, 0, 1, "t6_reset_uf");

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
